// File: rtl/sample_uart_tx.sv
// sample_uart_tx: queues strobed samples and sends each one as two self-framing UART bytes.
// Define SAMPLE_UART_TX_PARITY_EN to add an even-parity bit to every byte.
module sample_uart_tx #(
    parameter int DATA_IN_LEN     = 10,
    parameter int CLKS_PER_BIT    = 104,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_IN_LEN-1:0]     data_in,
    input  logic                       strobe_in,
    input  logic                       overflow_clr,
    output logic                       tx,
    output logic                       busy,
    output logic                       overflow,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;
    localparam int CW    = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SAMPLE_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                     state, state_n;
    logic [13:0]                mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]              baud;
    logic [2:0]                 bit_cnt;
    logic [15:0]                shift;
    logic                       byte_sel, strobe_q, tx_n;
    logic                       push_req, push, pop, full, empty, baud_done;
`ifdef SAMPLE_UART_TX_PARITY_EN
    logic                       par;
`endif

    assign empty     = fifo_level == '0;
    assign full      = fifo_level == LW'(DEPTH);
    assign push_req  = strobe_in & ~strobe_q;
    assign pop       = (state == IDLE) && !empty;
    // A push while full is still accepted when the head leaves at the same edge.
    assign push      = push_req && (!full || pop);
    assign busy      = (state != IDLE) || !empty;
    assign baud_done = baud == CW'(CLKS_PER_BIT - 1);

    always_comb begin
        state_n = state;
        tx_n    = 1'b1;
        case (state)
            IDLE:   state_n = empty ? IDLE : START;
            START: begin
                tx_n    = 1'b0;
                state_n = baud_done ? DATA : START;
            end
            DATA: begin
                tx_n = shift[0];
`ifdef SAMPLE_UART_TX_PARITY_EN
                state_n = (baud_done && bit_cnt == 3'd7) ? PARITY : DATA;
`else
                state_n = (baud_done && bit_cnt == 3'd7) ? STOP : DATA;
`endif
            end
`ifdef SAMPLE_UART_TX_PARITY_EN
            PARITY: begin
                tx_n    = par;
                state_n = baud_done ? STOP : PARITY;
            end
`endif
            STOP:    state_n = baud_done ? (byte_sel ? IDLE : START) : STOP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= 14'(data_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            baud       <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_sel   <= 1'b0;
            strobe_q   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
`ifdef SAMPLE_UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            tx         <= tx_n;
            strobe_q   <= strobe_in;
            baud       <= (state_n != state || baud_done) ? '0 : baud + 1'b1;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            overflow   <= (push_req && !push) || (overflow && !overflow_clr);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            // byte1 sits above byte0 so it lands in the low byte after byte0 shifts out.
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                shift    <= {1'b0, mem[rd_ptr][6:0], 1'b1, mem[rd_ptr][13:7]};
                byte_sel <= 1'b0;
            end
            if (state == DATA && baud_done) begin
                shift   <= shift >> 1;
                bit_cnt <= bit_cnt + 1'b1;
`ifdef SAMPLE_UART_TX_PARITY_EN
                par     <= par ^ shift[0];
`endif
            end
`ifdef SAMPLE_UART_TX_PARITY_EN
            if (state == START) par <= 1'b0;
`endif
            if (state == STOP && baud_done) byte_sel <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sample_uart_tx.sv
// tb_sample_uart_tx: scoreboarded UART decode of sample_uart_tx with CLKS_PER_BIT=4.
module tb_sample_uart_tx;
    localparam int CPB = 4;
`ifdef SAMPLE_UART_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME = 2 * BITS * CPB;

    logic       clk = 1'b0, reset = 1'b1, strobe_in = 1'b0, overflow_clr = 1'b0;
    logic [9:0] data_in = '0;
    logic       tx, busy, overflow;
    logic [2:0] fifo_level;
    int         n_chk = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    logic       rx_en = 1'b1, rx_active = 1'b0;

    typedef struct {
        logic [9:0] d;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    sample_uart_tx #(.DATA_IN_LEN(10), .CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(2)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .strobe_in(strobe_in),
        .overflow_clr(overflow_clr), .tx(tx), .busy(busy), .overflow(overflow),
        .fifo_level(fifo_level)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_push(input logic [9:0] d);
        logic [13:0] s;
        s = 14'(d);
        exp_q.push_back({1'b1, s[13:7]});
        exp_q.push_back({1'b0, s[6:0]});
    endfunction

    task automatic pulse(input logic [9:0] d);
        @(negedge clk);
        data_in   = d;
        strobe_in = 1'b1;
        @(negedge clk);
        strobe_in = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || rx_active) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(busy || rx_active), 0);
        repeat (2) @(negedge clk);
    endtask

    // UART receiver: samples mid-bit on negedges and scores against exp_q.
    initial begin
        logic [7:0] b, e;
        logic       p;
        forever begin
            @(negedge clk);
            if (rx_en && !reset && tx === 1'b0) begin
                rx_active = 1'b1;
                repeat (CPB + CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = tx;
                    if (i < 7) repeat (CPB) @(negedge clk);
                end
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
`ifdef SAMPLE_UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                p = tx;
                check("rx_parity", p, ^e);
`else
                p = 1'b0;
`endif
                repeat (CPB) @(negedge clk);
                check("rx_stop", tx, 1);
                check("rx_byte", b, e);
                rx_active = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mx, tr;
        int exp_lvl[6];
        logic prev;
        vecs[0] = '{10'h2AB, 8'h85, 8'h2B};
        vecs[1] = '{10'h000, 8'h80, 8'h00};
        vecs[2] = '{10'h3FF, 8'h87, 8'h7F};
        vecs[3] = '{10'h001, 8'h80, 8'h01};
        vecs[4] = '{10'h200, 8'h84, 8'h00};
        exp_lvl = '{1, 1, 2, 3, 4, 4};

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_level", fifo_level, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(vecs[i].b0);
            exp_q.push_back(vecs[i].b1);
            pulse(vecs[i].d);
            wait_idle("vec_idle");
            check("vec_all_bytes", exp_q.size(), 0);
        end

        // Capture/pop/start latency and frame length
        exp_q.push_back(8'h85);
        exp_q.push_back(8'h2B);
        @(negedge clk);
        data_in = 10'h2AB;
        strobe_in = 1'b1;
        @(negedge clk);
        check("t1_level_push", fifo_level, 1);
        check("t1_busy", busy, 1);
        check("t1_tx_n", tx, 1);
        strobe_in = 1'b0;
        @(negedge clk);
        check("t1_level_pop", fifo_level, 0);
        check("t1_tx_n1", tx, 1);
        @(negedge clk);
        check("t1_tx_start", tx, 0);
        repeat (FRAME - 2) @(negedge clk);
        check("t1_tx_last_stop", tx, 1);
        check("t1_busy_last_stop", busy, 1);
        @(negedge clk);
        check("t1_tx_stop_end", tx, 1);
        @(negedge clk);
        check("t1_busy_done", busy, 0);
        check("t1_overflow", overflow, 0);
        wait_idle("t1_idle");
        check("t1_all_bytes", exp_q.size(), 0);

        // Held strobe gives one sample
        exp_push(10'h001);
        @(negedge clk);
        data_in = 10'h001;
        strobe_in = 1'b1;
        mx = 0;
        repeat (10) begin
            @(negedge clk);
            if (int'(fifo_level) > mx) mx = int'(fifo_level);
        end
        strobe_in = 1'b0;
        check("t2_level_max_le1", int'(mx <= 1), 1);
        wait_idle("t2_idle");
        check("t2_all_bytes", exp_q.size(), 0);

        // Fill, overflow, set-beats-clear, clear
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            data_in = 10'(i + 1);
            strobe_in = 1'b1;
            if (i < 5) exp_push(10'(i + 1));
            @(negedge clk);
            check("t3_level", fifo_level, exp_lvl[i]);
            check("t3_overflow", overflow, int'(i == 5));
            strobe_in = 1'b0;
            @(negedge clk);
            if (i == 0) check("t3_first_pop", fifo_level, 0);
        end
        data_in = 10'd7;
        strobe_in = 1'b1;
        overflow_clr = 1'b1;
        @(negedge clk);
        check("t3_set_wins", overflow, 1);
        check("t3_level_full", fifo_level, 4);
        strobe_in = 1'b0;
        overflow_clr = 1'b0;
        wait_idle("t3_idle");
        check("t3_all_bytes", exp_q.size(), 0);
        check("t3_overflow_sticky", overflow, 1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("t3_overflow_clr", overflow, 0);

        // Push into a full FIFO on the same edge as the IDLE pop
        exp_push(10'h101);
        pulse(10'h101);
        for (int k = 0; k < 4; k++) begin
            exp_push(10'(10'h102 + k));
            pulse(10'(10'h102 + k));
        end
        check("t4_full", fifo_level, 4);
        repeat (FRAME - 7) @(negedge clk);
        check("t4_before_pop", fifo_level, 4);
        data_in = 10'h106;
        strobe_in = 1'b1;
        exp_push(10'h106);
        @(negedge clk);
        check("t4_level_same", fifo_level, 4);
        check("t4_no_overflow", overflow, 0);
        strobe_in = 1'b0;
        wait_idle("t4_idle");
        check("t4_all_bytes", exp_q.size(), 0);

        // Async reset during byte0 data bit 3
        rx_en = 1'b0;
        pulse(10'h155);
        pulse(10'h0AA);
        check("t5_level_before", fifo_level, 1);
        repeat (17) @(negedge clk);
        check("t5_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("t5_tx", tx, 1);
        check("t5_busy", busy, 0);
        check("t5_level", fifo_level, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tr = 0;
        prev = tx;
        repeat (200) begin
            @(negedge clk);
            if (tx != prev) tr++;
            prev = tx;
        end
        check("t5_tx_quiet", tr, 0);
        check("t5_busy_after", busy, 0);
        rx_en = 1'b1;

        exp_push(10'h2AB);
        pulse(10'h2AB);
        wait_idle("post_idle");
        check("post_all_bytes", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
